// File: rtl/longframe_sync.sv
// ---------------------------------------------------------------------------
// longframe_sync
//
// Frame-sync receiver for a long-frame strobe: one pulse of DELAY clocks at
// the start of every PERIOD-clock frame. The block measures the pulse width
// and the spacing of rising edges. It acquires lock after LOCK_CNT
// consecutive good frames, then flywheels a local frame phase counter that
// is never realigned while locked. Lock is dropped after MISS_CNT
// consecutive bad frames.
//
// Ports
//   clk         : clock, all logic on posedge
//   rst         : synchronous, active-high reset
//   strb        : long-frame strobe, synchronous to clk
//   locked      : high while the receiver is locked
//   frame_start : one-cycle pulse when phase == 0 while locked
//   phase       : frame position 0..PERIOD-1 (0 = cycle after a sampled rise)
//   width_err   : one-cycle pulse when a measured pulse width != DELAY
//   period_err  : one-cycle pulse on a mistimed or missing rising edge
// ---------------------------------------------------------------------------
module longframe_sync #(
    parameter int DELAY    = 8,
    parameter int PERIOD   = 256,
    parameter int LOCK_CNT = 3,
    parameter int MISS_CNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       strb,
    output logic       locked,
    output logic       frame_start,
    output logic [7:0] phase,
    output logic       width_err,
    output logic       period_err
);

    localparam logic [7:0]  PERIOD_M1 = 8'(PERIOD - 1);
    localparam logic [7:0]  DELAY_W   = 8'(DELAY);
    localparam logic [15:0] LOCK_W    = 16'(LOCK_CNT);
    localparam logic [15:0] MISS_W    = 16'(MISS_CNT);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        prev_r;
    logic [7:0]  wcnt_r;
    logic        width_ok_r;
    logic [7:0]  phase_r;
    logic [7:0]  phase_nxt_s;
    logic [15:0] good_r;
    logic [15:0] good_nxt_s;
    logic [15:0] miss_r;
    logic [15:0] miss_nxt_s;
    logic        perr_nxt_s;
    logic        locked_r;
    logic        frame_start_r;
    logic        width_err_r;
    logic        period_err_r;

    logic        rise_s;
    logic        fall_s;
    logic        at_end_s;
    logic        good_rise_s;

    // Edge detection against the previous sample; the frame-end test and the
    // good-frame qualifier use the width verdict of the preceding pulse.
    always_comb begin
        rise_s      = strb & ~prev_r;
        fall_s      = ~strb & prev_r;
        at_end_s    = (phase_r == PERIOD_M1);
        good_rise_s = rise_s & at_end_s & width_ok_r;
    end

    // Pulse width measurement: counts high samples including the rising one,
    // so a pulse of DELAY clocks reads exactly DELAY at the falling sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r      <= 1'b0;
            wcnt_r      <= 8'd0;
            width_ok_r  <= 1'b0;
            width_err_r <= 1'b0;
        end else begin
            prev_r      <= strb;
            width_err_r <= fall_s & (wcnt_r != DELAY_W);
            if (rise_s) begin
                wcnt_r     <= 8'd1;
                width_ok_r <= 1'b0;
            end else if (fall_s) begin
                wcnt_r     <= wcnt_r;
                width_ok_r <= (wcnt_r == DELAY_W);
            end else if (strb) begin
                wcnt_r     <= (wcnt_r == 8'hFF) ? wcnt_r : (wcnt_r + 8'd1);
                width_ok_r <= width_ok_r;
            end else begin
                wcnt_r     <= wcnt_r;
                width_ok_r <= width_ok_r;
            end
        end
    end

    // Acquisition / flywheel decisions for the next cycle.
    always_comb begin
        state_nxt_s = state_r;
        phase_nxt_s = phase_r;
        good_nxt_s  = good_r;
        miss_nxt_s  = miss_r;
        perr_nxt_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                phase_nxt_s = 8'd0;
                good_nxt_s  = 16'd0;
                miss_nxt_s  = 16'd0;
                if (rise_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_CHECK: begin
                if (rise_s) begin
                    phase_nxt_s = 8'd0;
                    if (good_rise_s) begin
                        good_nxt_s = good_r + 16'd1;
                        if ((good_r + 16'd1) == LOCK_W) begin
                            state_nxt_s = ST_LOCKED;
                            miss_nxt_s  = 16'd0;
                        end else begin
                            state_nxt_s = ST_CHECK;
                        end
                    end else begin
                        // Only a timing fault is reported; a width-only
                        // failure just restarts the good-frame count.
                        good_nxt_s  = 16'd0;
                        perr_nxt_s  = ~at_end_s;
                        state_nxt_s = ST_CHECK;
                    end
                end else if (at_end_s) begin
                    perr_nxt_s  = 1'b1;
                    state_nxt_s = ST_HUNT;
                    phase_nxt_s = 8'd0;
                    good_nxt_s  = 16'd0;
                end else begin
                    phase_nxt_s = phase_r + 8'd1;
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_LOCKED: begin
                // Free-running phase; a stray rise never realigns it.
                phase_nxt_s = at_end_s ? 8'd0 : (phase_r + 8'd1);
                if (at_end_s) begin
                    if (good_rise_s) begin
                        miss_nxt_s = 16'd0;
                    end else begin
                        miss_nxt_s = miss_r + 16'd1;
                        perr_nxt_s = ~rise_s;
                    end
                end else if (rise_s) begin
                    miss_nxt_s = miss_r + 16'd1;
                    perr_nxt_s = 1'b1;
                end else begin
                    miss_nxt_s = miss_r;
                end
                if (miss_nxt_s >= MISS_W) begin
                    state_nxt_s = ST_HUNT;
                    phase_nxt_s = 8'd0;
                    miss_nxt_s  = 16'd0;
                    good_nxt_s  = 16'd0;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                phase_nxt_s = 8'd0;
                good_nxt_s  = 16'd0;
                miss_nxt_s  = 16'd0;
            end
        endcase
    end

    // State and registered outputs; outputs are derived from next-state so
    // they line up with the phase value they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_HUNT;
            phase_r       <= 8'd0;
            good_r        <= 16'd0;
            miss_r        <= 16'd0;
            locked_r      <= 1'b0;
            frame_start_r <= 1'b0;
            period_err_r  <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            phase_r       <= phase_nxt_s;
            good_r        <= good_nxt_s;
            miss_r        <= miss_nxt_s;
            locked_r      <= (state_nxt_s == ST_LOCKED);
            frame_start_r <= (state_nxt_s == ST_LOCKED) && (phase_nxt_s == 8'd0);
            period_err_r  <= perr_nxt_s;
        end
    end

    assign locked      = locked_r;
    assign frame_start = frame_start_r;
    assign phase       = phase_r;
    assign width_err   = width_err_r;
    assign period_err  = period_err_r;

endmodule

// File: tb/tb_longframe_sync.sv
// ---------------------------------------------------------------------------
// tb_longframe_sync
//
// Directed frame sequences followed by randomized frame perturbations. A
// time-based reference model (frame anchors and edge indices) predicts the
// outputs for every clock; predictions are queued and a separate monitor
// compares them against the DUT on the falling edge.
// ---------------------------------------------------------------------------
module tb_longframe_sync;

    localparam int DELAY    = 8;
    localparam int PERIOD   = 256;
    localparam int LOCK_CNT = 3;
    localparam int MISS_CNT = 2;

    localparam int M_HUNT   = 0;
    localparam int M_CHECK  = 1;
    localparam int M_LOCKED = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strb = 1'b0;
    logic       locked;
    logic       frame_start;
    logic [7:0] phase;
    logic       width_err;
    logic       period_err;

    always #5 clk = ~clk;

    longframe_sync #(
        .DELAY   (DELAY),
        .PERIOD  (PERIOD),
        .LOCK_CNT(LOCK_CNT),
        .MISS_CNT(MISS_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .strb       (strb),
        .locked     (locked),
        .frame_start(frame_start),
        .phase      (phase),
        .width_err  (width_err),
        .period_err (period_err)
    );

    typedef struct packed {
        logic       lk;
        logic       fs;
        logic [7:0] ph;
        logic       we;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mon_cyc  = 0;

    // Reference model state (written only by the driver process)
    int m_mode   = M_HUNT;
    int m_anchor = 0;     // edge index at which phase was last set to 0
    int m_edge   = 0;     // index of the current posedge
    int m_good   = 0;
    int m_miss   = 0;
    int m_hi     = 0;     // high samples in the current/last pulse
    bit m_prev   = 1'b0;
    bit m_wok    = 1'b0;

    task automatic model_step(input logic s, input logic r);
        exp_t x;
        bit   rise, fall, wok_used, at_end;
        int   hs, ph;
        x = '0;
        if (r) begin
            m_mode = M_HUNT; m_prev = 1'b0; m_hi = 0; m_wok = 1'b0;
            m_good = 0; m_miss = 0;
        end else begin
            rise     = s && !m_prev;
            fall     = !s && m_prev;
            wok_used = m_wok;
            m_prev   = s;
            hs       = (m_hi > 255) ? 255 : m_hi;
            if (fall) begin
                x.we  = (hs != DELAY);
                m_wok = (hs == DELAY);
            end
            if (rise) begin
                m_wok = 1'b0;
                m_hi  = 1;
            end else if (s) begin
                m_hi = m_hi + 1;
            end
            case (m_mode)
                M_HUNT: begin
                    if (rise) begin
                        m_mode = M_CHECK; m_anchor = m_edge; m_good = 0;
                    end
                end
                M_CHECK: begin
                    at_end = ((m_edge - m_anchor) == PERIOD);
                    if (rise) begin
                        m_anchor = m_edge;
                        if (at_end && wok_used) begin
                            m_good = m_good + 1;
                            if (m_good == LOCK_CNT) begin
                                m_mode = M_LOCKED; m_miss = 0;
                            end
                        end else begin
                            x.pe   = !at_end;
                            m_good = 0;
                        end
                    end else if (at_end) begin
                        x.pe = 1'b1; m_mode = M_HUNT;
                    end
                end
                default: begin
                    at_end = (((m_edge - m_anchor) % PERIOD) == 0);
                    if (at_end) begin
                        if (rise && wok_used) m_miss = 0;
                        else begin
                            m_miss = m_miss + 1;
                            x.pe   = !rise;
                        end
                    end else if (rise) begin
                        x.pe = 1'b1; m_miss = m_miss + 1;
                    end
                    if (m_miss >= MISS_CNT) begin
                        m_mode = M_HUNT; m_miss = 0;
                    end
                end
            endcase
            if (m_mode == M_HUNT)       ph = 0;
            else if (m_mode == M_CHECK) ph = m_edge - m_anchor;
            else                        ph = (m_edge - m_anchor) % PERIOD;
            x.ph = 8'(ph);
            x.lk = (m_mode == M_LOCKED);
            x.fs = x.lk && (ph == 0);
        end
        exp_q.push_back(x);
        m_edge = m_edge + 1;
    endtask

    task automatic step(input logic s, input logic r);
        strb = s;
        rst  = r;
        @(posedge clk);
        model_step(s, r);
        #1;
    endtask

    task automatic frame(input int hi, input int total);
        for (int i = 0; i < total; i++) step(i < hi, 1'b0);
    endtask

    // Frame with a second pulse of xhi clocks starting at offset 'at'
    task automatic frame_x(input int hi, input int total, input int at, input int xhi);
        for (int i = 0; i < total; i++)
            step((i < hi) || ((i >= at) && (i < at + xhi)), 1'b0);
    endtask

    task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL cyc=%0d %s got=%0h exp=%0h", mon_cyc, nm, got, want);
        end
    endtask

    // Monitor: one prediction per clock, compared away from the active edge
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                cmp("locked",      {7'd0, locked},      {7'd0, x.lk});
                cmp("frame_start", {7'd0, frame_start}, {7'd0, x.fs});
                cmp("phase",       phase,               x.ph);
                cmp("width_err",   {7'd0, width_err},   {7'd0, x.we});
                cmp("period_err",  {7'd0, period_err},  {7'd0, x.pe});
                mon_cyc = mon_cyc + 1;
            end
        end
    end

    // Stimulus
    initial begin
        int sel;
        repeat (3) step(1'b0, 1'b1);
        // Ideal strobe from reset
        repeat (6) frame(DELAY, PERIOD);
        // Short pulse on the 2nd frame while checking
        step(1'b0, 1'b1);
        frame(DELAY, PERIOD);
        frame(DELAY - 1, PERIOD);
        repeat (6) frame(DELAY, PERIOD);
        // Locked: single omission, then double omission and relock
        frame(0, PERIOD);
        repeat (2) frame(DELAY, PERIOD);
        repeat (2) frame(0, PERIOD);
        repeat (6) frame(DELAY, PERIOD);
        // Locked: extra rise at phase 100
        frame_x(DELAY, PERIOD, 101, DELAY);
        repeat (3) frame(DELAY, PERIOD);
        // Reset mid-lock, then relock
        frame(DELAY, 130);
        step(1'b0, 1'b1);
        repeat (6) frame(DELAY, PERIOD);
        // 255-clock period while checking
        step(1'b0, 1'b1);
        frame(DELAY, PERIOD);
        frame(DELAY, PERIOD - 1);
        repeat (5) frame(DELAY, PERIOD);
        // Reset in the middle of a high pulse: truncated width
        frame(DELAY, PERIOD);
        frame(DELAY / 2, DELAY / 2);
        step(1'b1, 1'b1);
        frame(DELAY / 2, PERIOD);
        repeat (5) frame(DELAY, PERIOD);
        // Randomized perturbations
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 14);
            case (sel)
                6:  frame(($urandom_range(0, 1) != 0) ? DELAY + 1 : DELAY - 1, PERIOD);
                7:  frame(DELAY, PERIOD + $urandom_range(0, 6) - 3);
                8:  frame(0, PERIOD);
                9:  frame_x(DELAY, PERIOD, $urandom_range(DELAY + 2, PERIOD - 2 * DELAY - 2),
                            $urandom_range(1, DELAY));
                10: begin
                    frame(DELAY, $urandom_range(1, PERIOD - 1));
                    step(1'b0, 1'b1);
                end
                default: frame(DELAY, PERIOD);
            endcase
        end
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
